// File: rtl/nibble_serial_subtractor.sv
// Serial subtractor: diff = a - b, one 4-bit carry-lookahead slice per clock in a + ~b + 1 form.
// A start/busy/done handshake sequences each operation. Results are held until the next completion.
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("nibble_serial_subtractor: WIDTH must be a multiple of 4 and at least 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             a_msb;
    logic             b_msb;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] wdiff;

    logic             accept;
    logic [4:0]       slice;
    logic [WIDTH+3:0] wdiff_sh;
    logic [WIDTH-1:0] wdiff_nx;

    // Standard 4-bit lookahead slice; returns {c4, sum[3:0]}.
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                        input logic cin);
        logic [3:0] p;
        logic [3:0] g;
        logic       c1;
        logic       c2;
        logic       c3;
        logic       c4;
        p  = x ^ y;
        g  = x & y;
        c1 = g[0] | (p[0] & cin);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin);
        return {c4, p ^ {c3, c2, c1, cin}};
    endfunction

    assign accept = start && ((state == IDLE) || (state == DONE));

    // Operands shift right one nibble per cycle; the sum nibble enters at the top of the
    // working diff, so after N cycles nibble 0 has reached the least significant position.
    always_comb begin
        slice    = cla4(opa[3:0], ~opb[3:0], carry);
        wdiff_sh = {slice[3:0], wdiff};
        wdiff_nx = wdiff_sh[WIDTH+3:4];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            opa      <= '0;
            opb      <= '0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            carry    <= 1'b0;
            cnt      <= '0;
            wdiff    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            diff     <= '0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                opa   <= a;
                opb   <= b;
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
                carry <= 1'b1;
                cnt   <= '0;
                wdiff <= '0;
                state <= RUN;
                busy  <= 1'b1;
            end else begin
                case (state)
                    RUN: begin
                        opa   <= opa >> 4;
                        opb   <= opb >> 4;
                        wdiff <= wdiff_nx;
                        carry <= slice[4];
                        cnt   <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state    <= DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            diff     <= wdiff_nx;
                            borrow   <= ~slice[4];
                            overflow <= (a_msb != b_msb) && (wdiff_nx[WIDTH-1] != a_msb);
                            zero     <= (wdiff_nx == '0);
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Bench for nibble_serial_subtractor: directed handshake/corner scenarios on a 16-bit instance,
// plus concurrent random back-to-back regression on 16-bit and 8-bit instances.
module tb_nibble_serial_subtractor;

    localparam int N16 = 4;
    localparam int N8  = 2;
    localparam int RAND_OPS = 10000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start16, start8;
    logic [15:0] a16, b16;
    logic [7:0]  a8, b8;
    logic        busy16, done16, borrow16, ovf16, zero16;
    logic        busy8, done8, borrow8, ovf8, zero8;
    logic [15:0] diff16;
    logic [7:0]  diff8;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] d;
        logic        br;
        logic        ov;
        logic        z;
    } exp_t;

    exp_t q16[$];
    exp_t q8[$];
    exp_t e16, e8;

    nibble_serial_subtractor #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .diff(diff16), .borrow(borrow16),
        .overflow(ovf16), .zero(zero16)
    );

    nibble_serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8),
        .overflow(ovf8), .zero(zero8)
    );

    function automatic exp_t model(input int w, input logic [15:0] x, input logic [15:0] y);
        exp_t        e;
        logic [15:0] mask;
        mask = 16'hFFFF >> (16 - w);
        x    = x & mask;
        y    = y & mask;
        e.d  = (x - y) & mask;
        e.br = (x < y);
        e.ov = (x[w-1] != y[w-1]) && (e.d[w-1] != x[w-1]);
        e.z  = (e.d == 16'h0000);
        return e;
    endfunction

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 9))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Scoreboards: every done pulse pops the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done16 === 1'b1) begin
            checks++;
            if (q16.size() == 0) begin
                errors++;
                $display("FAIL sb16_unexpected_done: diff=%h with no operation pending", diff16);
            end else begin
                e16 = q16.pop_front();
                if ({diff16, borrow16, ovf16, zero16} !== {e16.d, e16.br, e16.ov, e16.z}) begin
                    errors++;
                    $display("FAIL sb16_result: diff=%h borrow=%b ovf=%b zero=%b, required diff=%h borrow=%b ovf=%b zero=%b",
                             diff16, borrow16, ovf16, zero16, e16.d, e16.br, e16.ov, e16.z);
                end
            end
        end
        if (rst_n === 1'b1 && done8 === 1'b1) begin
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL sb8_unexpected_done: diff=%h with no operation pending", diff8);
            end else begin
                e8 = q8.pop_front();
                if ({diff8, borrow8, ovf8, zero8} !== {e8.d[7:0], e8.br, e8.ov, e8.z}) begin
                    errors++;
                    $display("FAIL sb8_result: diff=%h borrow=%b ovf=%b zero=%b, required diff=%h borrow=%b ovf=%b zero=%b",
                             diff8, borrow8, ovf8, zero8, e8.d[7:0], e8.br, e8.ov, e8.z);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch16(input logic [15:0] x, input logic [15:0] y, input bit push);
        a16     = x;
        b16     = y;
        start16 = 1'b1;
        if (push) q16.push_back(model(16, x, y));
        step();
        start16 = 1'b0;
    endtask

    task automatic launch8(input logic [7:0] x, input logic [7:0] y);
        a8     = x;
        b8     = y;
        start8 = 1'b1;
        q8.push_back(model(8, {8'h00, x}, {8'h00, y}));
        step();
        start8 = 1'b0;
    endtask

    // Called in the first RUN cycle; walks the N busy cycles and stops in the DONE cycle.
    task automatic expect_run16(input logic [15:0] held, input string tag);
        for (int i = 0; i < N16; i++) begin
            checks++;
            if (busy16 !== 1'b1 || done16 !== 1'b0 || diff16 !== held) begin
                errors++;
                $display("FAIL %s_run%0d: busy=%b done=%b diff=%h, required busy=1 done=0 diff=%h",
                         tag, i, busy16, done16, diff16, held);
            end
            step();
        end
        checks++;
        if (done16 !== 1'b1 || busy16 !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: done=%b busy=%b, required done=1 busy=0", tag, done16, busy16);
        end
    endtask

    task automatic leave_done16(input string tag);
        step();
        checks++;
        if (done16 !== 1'b0 || busy16 !== 1'b0) begin
            errors++;
            $display("FAIL %s_after_done: done=%b busy=%b, required 0 0", tag, done16, busy16);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        start16 = 1'b1;
        start8  = 1'b1;
        a16 = 16'hFFFF; b16 = 16'h0000;
        a8  = 8'hFF;    b8  = 8'h00;
        step();
        step();
        checks++;
        if ({busy16, done16, diff16, borrow16, ovf16, zero16} !== 21'd0) begin
            errors++;
            $display("FAIL reset16: outputs=%h, required 0", {busy16, done16, diff16, borrow16, ovf16, zero16});
        end
        checks++;
        if ({busy8, done8, diff8, borrow8, ovf8, zero8} !== 13'd0) begin
            errors++;
            $display("FAIL reset8: outputs=%h, required 0", {busy8, done8, diff8, borrow8, ovf8, zero8});
        end
        start16 = 1'b0;
        start8  = 1'b0;
        rst_n   = 1'b1;
        step();
        checks++;
        if (busy16 !== 1'b0 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_start_ignored: busy16=%b busy8=%b, required 0 0", busy16, busy8);
        end
    endtask

    task automatic test_basic();
        launch16(16'h1234, 16'h0234, 1'b1);
        expect_run16(16'h0000, "basic");
        leave_done16("basic");
    endtask

    task automatic test_borrow();
        launch16(16'h0000, 16'h0001, 1'b1);
        expect_run16(16'h1000, "wrap");
        leave_done16("wrap");
        launch16(16'hABCD, 16'hABCD, 1'b1);
        expect_run16(16'hFFFF, "equal");
        leave_done16("equal");
    endtask

    task automatic test_overflow();
        launch16(16'h8000, 16'h0001, 1'b1);
        expect_run16(16'h0000, "ovf_neg");
        leave_done16("ovf_neg");
        launch16(16'h7FFF, 16'hFFFF, 1'b1);
        expect_run16(16'h7FFF, "ovf_pos");
        leave_done16("ovf_pos");
    endtask

    task automatic test_start_in_run();
        launch16(16'h00F0, 16'h000F, 1'b1);
        checks++;
        if (busy16 !== 1'b1) begin
            errors++;
            $display("FAIL ignore_run1: busy=%b, required 1", busy16);
        end
        step();
        start16 = 1'b1;
        a16 = 16'hFFFF;
        b16 = 16'h0000;
        checks++;
        if (busy16 !== 1'b1) begin
            errors++;
            $display("FAIL ignore_run2: busy=%b, required 1", busy16);
        end
        step();
        start16 = 1'b0;
        for (int i = 0; i < N16 - 2; i++) begin
            checks++;
            if (busy16 !== 1'b1 || done16 !== 1'b0) begin
                errors++;
                $display("FAIL ignore_run%0d: busy=%b done=%b, required 1 0", i + 3, busy16, done16);
            end
            step();
        end
        checks++;
        if (done16 !== 1'b1) begin
            errors++;
            $display("FAIL ignore_done: done=%b, required 1", done16);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (done16 !== 1'b0 || busy16 !== 1'b0) begin
                errors++;
                $display("FAIL ignore_no_second: cycle %0d done=%b busy=%b, required 0 0", i, done16, busy16);
            end
        end
    endtask

    task automatic test_back_to_back();
        launch16(16'h0100, 16'h0001, 1'b1);
        expect_run16(16'h00E1, "b2b_first");
        launch16(16'h0005, 16'h0003, 1'b1);
        expect_run16(16'h00FF, "b2b_second");
        leave_done16("b2b_second");
    endtask

    task automatic test_reset_midrun();
        launch16(16'h1111, 16'h0001, 1'b0);
        step();
        step();
        rst_n = 1'b0;
        step();
        checks++;
        if ({busy16, done16, diff16, borrow16, ovf16, zero16} !== 21'd0) begin
            errors++;
            $display("FAIL midrun_reset: outputs=%h, required 0", {busy16, done16, diff16, borrow16, ovf16, zero16});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (done16 !== 1'b0 || busy16 !== 1'b0) begin
                errors++;
                $display("FAIL midrun_no_done: cycle %0d done=%b busy=%b, required 0 0", i, done16, busy16);
            end
        end
        launch16(16'h0010, 16'h0001, 1'b1);
        expect_run16(16'h0000, "after_reset");
        leave_done16("after_reset");
    endtask

    task automatic rand16_thread();
        logic [15:0] x, y;
        int cnt;
        x = pick16();
        y = ($urandom_range(0, 15) == 0) ? x : pick16();
        launch16(x, y, 1'b1);
        for (int i = 0; i < RAND_OPS; i++) begin
            cnt = 0;
            while (done16 !== 1'b1 && cnt < 40) begin
                step();
                cnt++;
            end
            checks++;
            if (cnt != N16) begin
                errors++;
                $display("FAIL rand16_spacing: op %0d done after %0d cycles, required %0d", i, cnt + 1, N16 + 1);
            end
            if (i < RAND_OPS - 1) begin
                x = pick16();
                y = ($urandom_range(0, 15) == 0) ? x : pick16();
                launch16(x, y, 1'b1);
            end else begin
                step();
            end
        end
    endtask

    task automatic rand8_thread();
        logic [15:0] x, y;
        int cnt;
        x = pick16();
        y = ($urandom_range(0, 15) == 0) ? x : pick16();
        launch8(x[7:0], y[7:0]);
        for (int i = 0; i < RAND_OPS; i++) begin
            cnt = 0;
            while (done8 !== 1'b1 && cnt < 40) begin
                step();
                cnt++;
            end
            checks++;
            if (cnt != N8) begin
                errors++;
                $display("FAIL rand8_spacing: op %0d done after %0d cycles, required %0d", i, cnt + 1, N8 + 1);
            end
            if (i < RAND_OPS - 1) begin
                x = pick16();
                y = ($urandom_range(0, 15) == 0) ? x : pick16();
                if (x[15]) x[7:0] = x[15:8];
                launch8(x[7:0], y[7:0]);
            end else begin
                step();
            end
        end
    endtask

    task automatic test_random();
        fork
            rand16_thread();
            rand8_thread();
        join
        step();
        checks++;
        if (q16.size() != 0 || q8.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: pending16=%0d pending8=%0d, required 0 0", q16.size(), q8.size());
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start16 = 1'b0;
        start8  = 1'b0;
        a16 = '0; b16 = '0;
        a8  = '0; b8  = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_borrow();
        test_overflow();
        test_start_in_run();
        test_back_to_back();
        test_reset_midrun();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
